// File: rtl/rwc_puf_seq_pkg.sv
// Shared FSM state type and rotate helper for the collision-PUF challenge sequencer.
package puf_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2,
        EMIT   = 2'd3
    } puf_state_e;

    localparam int ROT_MAXW = 64;

    // Rotate the low w bits of x left by sh (sh < w); bits above w come back zero.
    function automatic logic [ROT_MAXW-1:0] rotl(input logic [ROT_MAXW-1:0] x,
                                                 input int unsigned w,
                                                 input int unsigned sh);
        logic [ROT_MAXW-1:0] mask;
        mask = (w >= ROT_MAXW) ? {ROT_MAXW{1'b1}} : ((ROT_MAXW'(1) << w) - ROT_MAXW'(1));
        return ((x << sh) | (x >> (w - sh))) & mask;
    endfunction

endpackage

// File: rtl/rwc_puf_seq_if.sv
// Generator-side bus to rwc_ctrl plus the per-challenge result stream.
interface rwc_puf_seq_if #(
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int IW = 4
);
    logic          gen_enable;
    logic [DW-1:0] cha_data;
    logic [AW-1:0] cha_addr;
    logic          available;
    logic [DW-1:0] rsp_write;
    logic [DW-1:0] rsp_clean;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_idx;
    logic [DW-1:0] out_data;
    logic [DW-1:0] out_stable;
    logic          out_dirty;

    modport master (
        output gen_enable, cha_data, cha_addr, out_valid, out_idx, out_data, out_stable, out_dirty,
        input  available, rsp_write, rsp_clean, out_ready
    );

    modport slave (
        input  gen_enable, cha_data, cha_addr, out_valid, out_idx, out_data, out_stable, out_dirty,
        output available, rsp_write, rsp_clean, out_ready
    );
endinterface

// File: rtl/rwc_puf_seq_majority_acc.sv
// Per-bit repetition counters; yields majority vote and all-equal stability mask.
module puf_majority_acc #(
    parameter int DW       = 32,
    parameter int NUM_REPS = 5
) (
    input  logic          w_clk,
    input  logic          w_resetn,
    input  logic          clr,
    input  logic          acc,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] maj,
    output logic [DW-1:0] stable
);
    localparam int CW = $clog2(NUM_REPS + 1);

    logic [DW-1:0][CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        maj    = '0;
        stable = '0;
        for (int i = 0; i < DW; i++) begin
            if (clr)
                cnt_d[i] = '0;
            else if (acc && din[i])
                cnt_d[i] = cnt_q[i] + CW'(1);
            maj[i]    = cnt_q[i] > CW'(NUM_REPS / 2);
            stable[i] = (cnt_q[i] == '0) || (cnt_q[i] == CW'(NUM_REPS));
        end
    end

    always_ff @(posedge w_clk) begin
        if (!w_resetn) cnt_q <= '0;
        else           cnt_q <= cnt_d;
    end
endmodule

// File: rtl/rwc_puf_seq.sv
// Multi-challenge, multi-repetition PUF sequencer in front of rwc_ctrl; streams
// a majority response and stability mask per challenge.
module rwc_puf_seq
    import puf_pkg::*;
#(
    parameter int DW          = 32,
    parameter int AW          = 32,
    parameter int NUM_CHAL    = 16,
    parameter int NUM_REPS    = 5,
    parameter int ADDR_STRIDE = 1,
    parameter int SETTLE_CYC  = 64,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic          w_clk,
    input  logic          w_resetn,
    input  logic          start,
    input  logic [DW-1:0] chal_seed,
    input  logic [AW-1:0] base_addr,
    output logic          busy,
    output logic          done,
    output logic          err,
    rwc_puf_seq_if.master bus
);
    localparam int IW = (NUM_CHAL > 1)    ? $clog2(NUM_CHAL)    : 1;
    localparam int RW = (NUM_REPS > 1)    ? $clog2(NUM_REPS)    : 1;
    localparam int SW = (SETTLE_CYC > 1)  ? $clog2(SETTLE_CYC)  : 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    puf_state_e    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [RW-1:0] rep_q, rep_d;
    logic [SW-1:0] set_q, set_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [DW-1:0] seed_q, seed_d;
    logic [AW-1:0] base_q, base_d;
    logic          dirty_q, dirty_d;
    logic          gen_q, gen_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          acc_clr, acc_en;
    logic [DW-1:0] maj, stable;
    logic [31:0]   rot_sh;
    logic          emit;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        set_d   = set_q;
        tmo_d   = tmo_q;
        seed_d  = seed_q;
        base_d  = base_q;
        dirty_d = dirty_q;
        gen_d   = gen_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        acc_clr = 1'b0;
        acc_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // done_q marks the cycle after a run ends; a start there is dropped
                if (start && !done_q) begin
                    seed_d  = chal_seed;
                    base_d  = base_addr;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    rep_d   = '0;
                    tmo_d   = '0;
                    dirty_d = 1'b0;
                    acc_clr = 1'b1;
                    busy_d  = 1'b1;
                    gen_d   = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.available) begin
                    acc_en  = 1'b1;
                    dirty_d = dirty_q | (|bus.rsp_clean);
                    gen_d   = 1'b0;
                    tmo_d   = '0;
                    set_d   = '0;
                    state_d = SETTLE;
                end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    gen_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    tmo_d   = '0;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            SETTLE: begin
                if (set_q == SW'(SETTLE_CYC - 1)) begin
                    set_d = '0;
                    if (rep_q == RW'(NUM_REPS - 1)) begin
                        state_d = EMIT;
                    end else begin
                        rep_d   = rep_q + RW'(1);
                        gen_d   = 1'b1;
                        state_d = ISSUE;
                    end
                end else begin
                    set_d = set_q + SW'(1);
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    acc_clr = 1'b1;
                    dirty_d = 1'b0;
                    rep_d   = '0;
                    if (idx_q == IW'(NUM_CHAL - 1)) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        gen_d   = 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge w_clk) begin
        if (!w_resetn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rep_q   <= '0;
            set_q   <= '0;
            tmo_q   <= '0;
            seed_q  <= '0;
            base_q  <= '0;
            dirty_q <= 1'b0;
            gen_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            set_q   <= set_d;
            tmo_q   <= tmo_d;
            seed_q  <= seed_d;
            base_q  <= base_d;
            dirty_q <= dirty_d;
            gen_q   <= gen_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    puf_majority_acc #(.DW(DW), .NUM_REPS(NUM_REPS)) u_acc (
        .w_clk    (w_clk),
        .w_resetn (w_resetn),
        .clr      (acc_clr),
        .acc      (acc_en),
        .din      (bus.rsp_write),
        .maj      (maj),
        .stable   (stable)
    );

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;
    assign emit = (state_q == EMIT);

    assign rot_sh         = 32'(idx_q) % 32'(DW);
    assign bus.gen_enable = gen_q;
    assign bus.cha_data   = DW'(rotl(ROT_MAXW'(seed_q), DW, rot_sh));
    assign bus.cha_addr   = base_q + AW'(idx_q) * AW'(ADDR_STRIDE);

    // result fields read zero outside EMIT so idle counters never leak out
    assign bus.out_valid  = emit;
    assign bus.out_idx    = emit ? idx_q   : '0;
    assign bus.out_data   = emit ? maj     : '0;
    assign bus.out_stable = emit ? stable  : '0;
    assign bus.out_dirty  = emit & dirty_q;
endmodule

// File: tb/tb_rwc_puf_seq.sv
// Bench for rwc_puf_seq: BFM for rwc_ctrl, result monitor, majority reference model.
module tb_rwc_puf_seq;
    localparam int DW = 32, AW = 32, NC = 4, NR = 3, STR = 1, SC = 4, TO = 32, IW = 2;

    logic          w_clk = 1'b0;
    logic          w_resetn = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] chal_seed = '0;
    logic [AW-1:0] base_addr = '0;
    logic          busy, done, err;

    rwc_puf_seq_if #(.DW(DW), .AW(AW), .IW(IW)) bus ();

    rwc_puf_seq #(.DW(DW), .AW(AW), .NUM_CHAL(NC), .NUM_REPS(NR), .ADDR_STRIDE(STR),
                  .SETTLE_CYC(SC), .TIMEOUT_CYC(TO)) dut (
        .w_clk(w_clk), .w_resetn(w_resetn), .start(start), .chal_seed(chal_seed),
        .base_addr(base_addr), .busy(busy), .done(done), .err(err), .bus(bus));

    always #5 w_clk = ~w_clk;

    typedef struct {
        logic [IW-1:0] idx;
        logic [DW-1:0] data;
        logic [DW-1:0] stab;
        logic          dirty;
    } res_t;
    typedef struct {
        logic [DW-1:0] cd;
        logic [AW-1:0] ca;
    } meas_t;
    typedef struct {
        logic [DW-1:0] w [NR];
        logic [DW-1:0] c [NR];
        logic [DW-1:0] e_data;
        logic [DW-1:0] e_stab;
        logic          e_dirty;
    } vec_t;

    int nvec = 0, nerr = 0;
    res_t  got_q[$];
    meas_t meas_q[$];
    logic [DW-1:0] rw_q[$], rc_q[$];
    logic [DW-1:0] rw[NC][NR], rc[NC][NR];
    vec_t  tbl[NC];
    int    bfm_lat = 2;
    bit    bfm_on = 1'b1;
    bit    rand_rdy = 1'b0;
    int    done_cnt = 0;
    bit    ov_seen = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // rwc_ctrl stand-in: answers bfm_lat cycles after gen_enable rises
    initial begin
        int wcnt;
        wcnt = 0;
        bus.available = 1'b0;
        bus.rsp_write = '0;
        bus.rsp_clean = '0;
        forever begin
            @(posedge w_clk); #1;
            bus.available = 1'b0;
            if (bfm_on && bus.gen_enable) begin
                wcnt++;
                if (wcnt == bfm_lat) begin
                    bus.available = 1'b1;
                    bus.rsp_write = (rw_q.size() > 0) ? rw_q.pop_front() : '0;
                    bus.rsp_clean = (rc_q.size() > 0) ? rc_q.pop_front() : '0;
                    meas_q.push_back('{bus.cha_data, bus.cha_addr});
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge w_clk);
            if (w_resetn) begin
                if (bus.out_valid) ov_seen = 1'b1;
                if (bus.out_valid && bus.out_ready)
                    got_q.push_back('{bus.out_idx, bus.out_data, bus.out_stable, bus.out_dirty});
                if (done) done_cnt++;
            end
        end
    end

    initial begin
        forever begin
            @(posedge w_clk); #1;
            if (rand_rdy) bus.out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    function automatic logic [DW-1:0] m_rot(input logic [DW-1:0] s, input int k);
        logic [2*DW-1:0] t;
        t = {s, s} << (k % DW);
        return t[2*DW-1:DW];
    endfunction

    task automatic model(input int c, output logic [DW-1:0] d, output logic [DW-1:0] st,
                         output logic dy);
        int n;
        d = '0; st = '0; dy = 1'b0;
        for (int b = 0; b < DW; b++) begin
            n = 0;
            for (int r = 0; r < NR; r++) n += int'(rw[c][r][b]);
            d[b]  = (2 * n > NR);
            st[b] = (n == 0) || (n == NR);
        end
        for (int r = 0; r < NR; r++) if (rc[c][r] != '0) dy = 1'b1;
    endtask

    task automatic fill_random();
        for (int c = 0; c < NC; c++)
            for (int r = 0; r < NR; r++) begin
                rw[c][r] = ($urandom_range(0, 3) == 0) ? rw[c][0] ^ (32'd1 << $urandom_range(0, 31)) : $urandom;
                rc[c][r] = ($urandom_range(0, 4) == 0) ? $urandom : '0;
            end
    endtask

    task automatic load_bfm();
        rw_q.delete(); rc_q.delete(); meas_q.delete(); got_q.delete();
        done_cnt = 0; ov_seen = 1'b0;
        for (int c = 0; c < NC; c++)
            for (int r = 0; r < NR; r++) begin
                rw_q.push_back(rw[c][r]);
                rc_q.push_back(rc[c][r]);
            end
    endtask

    task automatic pulse_start(input logic [DW-1:0] s, input logic [AW-1:0] b);
        @(posedge w_clk); #1;
        start = 1'b1; chal_seed = s; base_addr = b;
        @(posedge w_clk); #1;
        start = 1'b0; chal_seed = $urandom; base_addr = $urandom;
    endtask

    task automatic wait_done(input string tag, input bit restart);
        int n;
        n = 0;
        while (!done && n < 3000) begin
            @(posedge w_clk); #1;
            n++;
        end
        chk({tag, "_done_seen"}, done, 1'b1);
        if (restart && done) begin
            start = 1'b1; chal_seed = $urandom; base_addr = $urandom;
            @(posedge w_clk); #1;
            start = 1'b0;
            chk({tag, "_start_at_done_busy"}, busy, 1'b0);
            chk({tag, "_start_at_done_gen"}, bus.gen_enable, 1'b0);
        end
        @(negedge w_clk);
    endtask

    task automatic check_run(input logic [DW-1:0] s, input logic [AW-1:0] b, input string tag);
        logic [DW-1:0] d, st;
        logic dy;
        int k;
        chk({tag, "_nres"}, got_q.size(), NC);
        chk({tag, "_nmeas"}, meas_q.size(), NC * NR);
        chk({tag, "_ndone"}, done_cnt, 1);
        chk({tag, "_busy_end"}, busy, 1'b0);
        for (int i = 0; i < got_q.size() && i < NC; i++) begin
            model(i, d, st, dy);
            chk({tag, "_idx"}, got_q[i].idx, i);
            chk({tag, "_data"}, got_q[i].data, d);
            chk({tag, "_stable"}, got_q[i].stab, st);
            chk({tag, "_dirty"}, got_q[i].dirty, dy);
        end
        for (int j = 0; j < meas_q.size() && j < NC * NR; j++) begin
            k = j / NR;
            chk({tag, "_cha_data"}, meas_q[j].cd, m_rot(s, k));
            chk({tag, "_cha_addr"}, meas_q[j].ca, AW'(b + AW'(k * STR)));
        end
    endtask

    initial begin
        logic [DW-1:0] s, sdata, sst;
        logic [AW-1:0] b;
        logic [IW-1:0] sidx;
        logic sdy;
        int n, bad;

        bus.out_ready = 1'b1;
        tbl[0].w = '{32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5}; tbl[0].c = '{0, 0, 0};
        tbl[0].e_data = 32'hA5A5_A5A5; tbl[0].e_stab = 32'hFFFF_FFFF; tbl[0].e_dirty = 1'b0;
        tbl[1].w = '{32'h1, 32'h3, 32'h2}; tbl[1].c = '{0, 0, 0};
        tbl[1].e_data = 32'h3; tbl[1].e_stab = 32'hFFFF_FFFC; tbl[1].e_dirty = 1'b0;
        tbl[2].w = '{32'hFFFF_0000, 32'hFF00_FF00, 32'hF0F0_F0F0}; tbl[2].c = '{0, 0, 32'h4};
        tbl[2].e_data = 32'hFFF0_F000; tbl[2].e_stab = 32'hF000_000F; tbl[2].e_dirty = 1'b1;
        tbl[3].w = '{32'h0, 32'h0, 32'h0}; tbl[3].c = '{0, 0, 0};
        tbl[3].e_data = 32'h0; tbl[3].e_stab = 32'hFFFF_FFFF; tbl[3].e_dirty = 1'b0;

        // reset values
        repeat (3) @(posedge w_clk);
        @(negedge w_clk);
        chk("rst_ctrl", {busy, done, err, bus.gen_enable, bus.out_valid, bus.out_dirty}, 6'b0);
        chk("rst_cha_data", bus.cha_data, 32'h0);
        chk("rst_cha_addr", bus.cha_addr, 32'h0);
        chk("rst_out_data", bus.out_data, 32'h0);
        chk("rst_out_stable", bus.out_stable, 32'h0);
        chk("rst_out_idx", bus.out_idx, 2'h0);
        @(posedge w_clk); #1;
        w_resetn = 1'b1;

        // table-driven vectors, one challenge per record
        for (int c = 0; c < NC; c++)
            for (int r = 0; r < NR; r++) begin
                rw[c][r] = tbl[c].w[r];
                rc[c][r] = tbl[c].c[r];
            end
        bfm_lat = 2;
        load_bfm();
        pulse_start(32'h1234_5678, 32'h0000_0100);
        wait_done("tbl", 1'b0);
        check_run(32'h1234_5678, 32'h0000_0100, "tbl");
        for (int i = 0; i < got_q.size() && i < NC; i++) begin
            chk("tbl_vec_data", got_q[i].data, tbl[i].e_data);
            chk("tbl_vec_stable", got_q[i].stab, tbl[i].e_stab);
            chk("tbl_vec_dirty", got_q[i].dirty, tbl[i].e_dirty);
        end

        // rotate and address wrap at idx 1
        for (int c = 0; c < NC; c++)
            for (int r = 0; r < NR; r++) begin rw[c][r] = '0; rc[c][r] = '0; end
        load_bfm();
        pulse_start(32'h8000_0001, 32'hFFFF_FFFF);
        wait_done("wrap", 1'b0);
        check_run(32'h8000_0001, 32'hFFFF_FFFF, "wrap");
        chk("wrap_idx0_data", (meas_q.size() > 0) ? meas_q[0].cd : 'x, 32'h8000_0001);
        chk("wrap_idx1_data", (meas_q.size() > NR) ? meas_q[NR].cd : 'x, 32'h0000_0003);
        chk("wrap_idx1_addr", (meas_q.size() > NR) ? meas_q[NR].ca : 'x, 32'h0000_0000);

        // first-result latency and long backpressure
        fill_random();
        bfm_lat = 1;
        bus.out_ready = 1'b0;
        s = $urandom; b = $urandom;
        load_bfm();
        pulse_start(s, b);
        n = 1;
        while (!bus.out_valid && n < 300) begin
            @(posedge w_clk); #1;
            n++;
        end
        chk("first_valid_latency", n, NR * (1 + SC) + 1);
        sidx = bus.out_idx; sdata = bus.out_data; sst = bus.out_stable; sdy = bus.out_dirty;
        bad = 0;
        repeat (100) begin
            @(posedge w_clk); #1;
            if (!bus.out_valid || bus.out_idx !== sidx || bus.out_data !== sdata ||
                bus.out_stable !== sst || bus.out_dirty !== sdy || bus.gen_enable) bad++;
        end
        chk("bp_hold_bad_cycles", bad, 0);
        chk("bp_no_xfer", got_q.size(), 0);
        bus.out_ready = 1'b1;
        @(posedge w_clk); #1;
        chk("bp_one_xfer", got_q.size(), 1);
        chk("bp_valid_drop", bus.out_valid, 1'b0);
        wait_done("bp", 1'b0);
        check_run(s, b, "bp");

        // timeout abort
        bfm_on = 1'b0;
        load_bfm();
        pulse_start($urandom, $urandom);
        n = 1;
        while (!done && n < TO + 50) begin
            @(posedge w_clk); #1;
            n++;
        end
        chk("to_cycles", n, TO + 1);
        chk("to_err", err, 1'b1);
        chk("to_gen", bus.gen_enable, 1'b0);
        chk("to_busy", busy, 1'b0);
        @(negedge w_clk);
        chk("to_no_valid", ov_seen, 1'b0);
        chk("to_ndone", done_cnt, 1);
        @(posedge w_clk); #1;
        chk("to_err_sticky", err, 1'b1);

        // recovery run clears err; random runs with backpressure, start-while-busy, start-at-done
        bfm_on = 1'b1;
        for (int k = 0; k < 4; k++) begin
            fill_random();
            bfm_lat = $urandom_range(1, 4);
            rand_rdy = (k != 0);
            s = $urandom; b = $urandom;
            load_bfm();
            pulse_start(s, b);
            chk("rnd_err_cleared", err, 1'b0);
            if (k == 0) begin
                repeat (5) @(posedge w_clk);
                #1;
                start = 1'b1; chal_seed = ~s; base_addr = ~b;
                @(posedge w_clk); #1;
                start = 1'b0;
            end
            wait_done("rnd", k == 1);
            rand_rdy = 1'b0;
            bus.out_ready = 1'b1;
            check_run(s, b, "rnd");
        end

        // reset in the middle of ISSUE
        bfm_on = 1'b0;
        load_bfm();
        pulse_start($urandom, $urandom);
        repeat (3) @(posedge w_clk);
        #1;
        chk("mid_rst_pre_gen", bus.gen_enable, 1'b1);
        w_resetn = 1'b0;
        @(posedge w_clk); #1;
        chk("mid_rst_gen", bus.gen_enable, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_valid", bus.out_valid, 1'b0);
        @(posedge w_clk); #1;
        w_resetn = 1'b1;
        bfm_on = 1'b1;
        bfm_lat = 2;
        fill_random();
        s = $urandom; b = $urandom;
        load_bfm();
        pulse_start(s, b);
        wait_done("post_rst", 1'b0);
        check_run(s, b, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
